iddmm_mul_pipe: RTL and testbench
=================================

# iddmm_mul_pipe

Parametrised, fully pipelined unsigned multiplier for the IDDMM Montgomery datapath. It generalises the fixed 128x128 multipliers: operand width and limb size are parameters, and a per-transaction mode selects a full 2W-bit product or its low W bits. It has valid/ready handshakes with optional backpressure and a sideband tag. It sits between the IDDMM sequencer and the modular-reduction stage. It accepts one product per cycle.

## Interface
- `W`, 128: operand width in bits; must be a multiple of `LIMB`.
- `LIMB`, 32: y-limb width; `N = W/LIMB` accumulation stages.
- `TAG_W`, 8: width of the sideband tag carried with each operation.
- `clk`  in  1: clock; all logic is rising-edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: operands present.
- `in_ready`  out  1: block accepts this cycle.
- `in_x`  in  W: multiplicand.
- `in_y`  in  W: multiplier.
- `in_low`  in  1: 1 = low-half mode, 0 = full product.
- `in_tag`  in  TAG_W: opaque tag returned with the result.
- `out_valid`  out  1: result present.
- `out_ready`  in  1: consumer accepts.
- `out_result`  out  2W: product; in low mode `[2W-1:W]` is forced to 0.
- `out_low`  out  1: echo of `in_low`.
- `out_tag`  out  TAG_W: echo of `in_tag`.

## Operation
- Transfer in: `in_valid && in_ready`. Transfer out: `out_valid && out_ready`.
- Pipeline: stage 0 registers x, y, low and tag.
  - Stage k (1..N) adds `(x * y[k*LIMB-1 -: LIMB]) << ((k-1)*LIMB)` into a 2W-bit accumulator.
  - Each stage carries its own valid bit, x, the remaining y limbs, low and tag.
- Arithmetic is unsigned and exact modulo 2^(2W). The accumulator never overflows 2W bits.
- Low mode: the upper W bits are masked at the output register only. The internal accumulation is identical in both modes.
- Global advance `adv = !out_valid || out_ready`. All stages shift when `adv` is high. `in_ready = adv`.
- Bubbles: invalid slots propagate with valid=0. Data in invalid slots is don't-care, but out_result must hold its last value while out_valid=0.
- Simultaneous accept and emit in one cycle is legal. Sustained throughput is 1 op/cycle when out_ready stays 1.
- Reset: all valid bits clear asynchronously. out_valid=0 and in_ready=1 (advance is true). out_result, out_low and out_tag reset to 0.
- Reset asserted mid-operation discards all in-flight operations. Nothing is emitted after deassertion until new inputs are accepted.

## Timing
- Latency L = N+1 cycles from the accepting edge to the edge at which out_valid rises (W=128, LIMB=32: L=5).
- With out_ready held 1, an op accepted at edge t appears at edge t+L, in order, with no gaps for back-to-back input.
- When out_valid=1 and out_ready=0, every stage holds and in_ready=0 in the same cycle (combinational from out_ready). No op is lost or duplicated.
- The first op is accepted on the first edge after rst deasserts if in_valid=1.

## Configuration
- `IDDMM_MUL_STALL_EN` defined: backpressure as described above.
- Undefined: `adv` tied to 1 and in_ready constant 1. out_ready is ignored; each result is presented for exactly one cycle. Saves the stall enable fanout for streaming sequencers.

## Structure
- Shared package `iddmm_pkg`:
  - default W / LIMB / TAG_W constants
  - a function returning N
  - a stage-record typedef (valid, x, y, acc, low, tag) parameterised through the package width constants.
- One sub-module, `iddmm_mul_row`: registered W x LIMB partial product plus shift-accumulate, with enable. It is instantiated N times via generate.
- Elaboration-time check: `W % LIMB == 0`, else `$fatal`.

## Test plan
All scenarios use W=128, LIMB=32, STALL_EN defined, and compare against a reference model `x*y` (low-masked when required).
- Full mode, x=y=2^128-1 -> out_result = 0xFFFF…FFFE 0000…0001 (2^256-2^129+1) at cycle 5, tag echoed.
- Low mode, x=2^128-1, y=3 -> out_result upper 128 bits 0, low = 0xFFFF…FFFD, out_low=1.
- 100 random back-to-back ops with alternating mode and tags 0..99 -> 100 results in order, one per cycle from cycle 5, all matching the reference model.
- Stall test: out_ready=0 for 7 cycles with 6 ops in flight -> in_ready=0 throughout, out_result stable. After release, all 6 ops emerge in order with no loss.
- Reset test: rst pulsed 2 cycles while 3 ops are in flight -> out_valid=0 immediately and no stale results after release. The next op (x=5, y=7) -> 35 at L=5.
- Zero and one operands: x=0, y=random -> 0; x=1, y=v -> v in full mode.

Source files
------------

// File: rtl/iddmm_pkg.sv
// Shared constants, stage count helper and pipeline stage record
// for the IDDMM multiplier datapath.
package iddmm_pkg;

    localparam int IDDMM_W     = 128;
    localparam int IDDMM_LIMB  = 32;
    localparam int IDDMM_TAG_W = 8;

    function automatic int iddmm_stages(input int w, input int limb);
        return w / limb;
    endfunction

    typedef struct packed {
        logic                     valid;
        logic [IDDMM_W-1:0]       x;
        logic [IDDMM_W-1:0]       y;
        logic [2*IDDMM_W-1:0]     acc;
        logic                     low;
        logic [IDDMM_TAG_W-1:0]   tag;
    } stage_t;

endpackage

// File: rtl/iddmm_mul_row.sv
// One accumulation row: W x LIMB partial product from the lowest
// remaining y limb, shifted into place and added to the accumulator.
module iddmm_mul_row
    import iddmm_pkg::*;
#(
    parameter int W     = IDDMM_W,
    parameter int LIMB  = IDDMM_LIMB,
    parameter int SHIFT = 0
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en_i,
    input  stage_t st_i,
    output stage_t st_o
);

    localparam int P = 2 * W;

    logic [P-1:0] pp;
    stage_t       st_d;
    stage_t       st_q;

    always_comb begin
        pp = P'(st_i.x[W-1:0]) * P'(st_i.y[LIMB-1:0]);
        st_d = '0;
        st_d.valid = st_i.valid;
        st_d.x = st_i.x;
        // consumed limb drops off so the next row sees its own limb at bit 0
        st_d.y = st_i.y >> LIMB;
        st_d.acc[P-1:0] = st_i.acc[P-1:0] + (pp << SHIFT);
        st_d.low = st_i.low;
        st_d.tag = st_i.tag;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q <= '0;
        end else if (en_i) begin
            st_q <= st_d;
        end
    end

    assign st_o = st_q;

endmodule

// File: rtl/iddmm_mul_pipe.sv
// Fully pipelined W x W unsigned multiplier, one op per cycle, latency N+1.
// Define IDDMM_MUL_STALL_EN to honour out_ready backpressure.
module iddmm_mul_pipe
    import iddmm_pkg::*;
#(
    parameter int W     = IDDMM_W,
    parameter int LIMB  = IDDMM_LIMB,
    parameter int TAG_W = IDDMM_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_x,
    input  logic [W-1:0]     in_y,
    input  logic             in_low,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_result,
    output logic             out_low,
    output logic [TAG_W-1:0] out_tag
);

    localparam int N = iddmm_stages(W, LIMB);

    if (W % LIMB != 0) begin : g_bad_limb
        $fatal(1, "iddmm_mul_pipe: W must be a multiple of LIMB");
    end
    if (W > IDDMM_W || TAG_W > IDDMM_TAG_W) begin : g_bad_width
        $fatal(1, "iddmm_mul_pipe: W/TAG_W exceed stage record width");
    end

    logic adv;

`ifdef IDDMM_MUL_STALL_EN
    assign adv = !out_valid || out_ready;
`else
    logic unused_out_ready;
    assign adv = 1'b1;
    assign unused_out_ready = out_ready;
`endif

    assign in_ready = adv;

    stage_t s0_d;
    stage_t s0_q;
    stage_t st [0:N];

    always_comb begin
        s0_d = '0;
        s0_d.valid = in_valid;
        s0_d.x[W-1:0] = in_x;
        s0_d.y[W-1:0] = in_y;
        s0_d.low = in_low;
        s0_d.tag[TAG_W-1:0] = in_tag;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_q <= '0;
        end else if (adv) begin
            s0_q <= s0_d;
        end
    end

    assign st[0] = s0_q;

    for (genvar k = 1; k <= N; k++) begin : g_row
        iddmm_mul_row #(
            .W     (W),
            .LIMB  (LIMB),
            .SHIFT ((k - 1) * LIMB)
        ) u_row (
            .clk  (clk),
            .rst  (rst),
            .en_i (adv),
            .st_i (st[k-1]),
            .st_o (st[k])
        );
    end

    logic unused_tail;
    assign unused_tail = ^{st[N].x, st[N].y};

    logic [2*W-1:0]   res_d;
    logic             out_valid_q;
    logic [2*W-1:0]   out_result_q;
    logic             out_low_q;
    logic [TAG_W-1:0] out_tag_q;

    // low-half masking happens only here; the rows never see the mode
    always_comb begin
        res_d = st[N].acc[2*W-1:0];
        if (st[N].low) begin
            res_d[2*W-1:W] = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_low_q    <= 1'b0;
            out_tag_q    <= '0;
        end else if (adv) begin
            out_valid_q <= st[N].valid;
            if (st[N].valid) begin
                out_result_q <= res_d;
                out_low_q    <= st[N].low;
                out_tag_q    <= st[N].tag[TAG_W-1:0];
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_low    = out_low_q;
    assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_iddmm_mul_pipe.sv
// Directed and random checks for iddmm_mul_pipe (W=128, LIMB=32).
module tb_iddmm_mul_pipe;

    localparam int W     = 128;
    localparam int LIMB  = 32;
    localparam int TAG_W = 8;
    localparam int L     = 5;
`ifdef IDDMM_MUL_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_x;
    logic [W-1:0]     in_y;
    logic             in_low;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   out_result;
    logic             out_low;
    logic [TAG_W-1:0] out_tag;

    iddmm_mul_pipe #(.W(W), .LIMB(LIMB), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_low     (in_low),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_low    (out_low),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*W-1:0]   res;
        logic             low;
        logic [TAG_W-1:0] tag;
        int               edge_n;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   lat_chk = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [2*W-1:0] got,
                         input logic [2*W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model(input logic [W-1:0] x,
                                             input logic [W-1:0] y,
                                             input logic low);
        logic [2*W-1:0] p;
        p = (2*W)'(x) * (2*W)'(y);
        if (low) p[2*W-1:W] = '0;
        return p;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && (out_ready || !STALL)) begin
            if (q.size() == 0) begin
                check("spurious", 256'(out_valid), 256'(0));
            end else begin
                e = q.pop_front();
                check("res", out_result, e.res);
                check("low", 256'(out_low), 256'(e.low));
                check("tag", 256'(out_tag), 256'(e.tag));
                if (lat_chk) check("lat", 256'(cyc - e.edge_n), 256'(L));
            end
        end
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic low, input logic [TAG_W-1:0] tag,
                        input logic [2*W-1:0] exp);
        int   n;
        exp_t e;
        n = 0;
        in_valid = 1'b1;
        in_x = x;
        in_y = y;
        in_low = low;
        in_tag = tag;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("send_timeout", 256'(in_ready), 256'(1));
            in_valid = 1'b0;
        end else begin
            e.res = exp;
            e.low = low;
            e.tag = tag;
            e.edge_n = cyc + 1;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", 256'(q.size()), 256'(0));
        idle(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0]   ones;
        logic [W-1:0]   rx;
        logic [W-1:0]   ry;
        logic [2*W-1:0] held;
        ones = '1;
        in_valid = 1'b0;
        in_x = '0;
        in_y = '0;
        in_low = 1'b0;
        in_tag = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_in_ready", 256'(in_ready), 256'(1));
        check("rst_result", out_result, 256'(0));
        check("rst_low", 256'(out_low), 256'(0));
        check("rst_tag", 256'(out_tag), 256'(0));
        rst = 1'b0;

        send(ones, ones, 1'b0, 8'hA5, {~128'd1, 128'd1});
        drain();
        send(ones, 128'd3, 1'b1, 8'h3C, {128'd0, ~128'd2});
        send(ones, 128'd3, 1'b0, 8'h3D, {128'd2, ~128'd2});
        drain();

        ry = {$urandom, $urandom, $urandom, $urandom};
        send('0, ry, 1'b0, 8'h01, 256'd0);
        send(128'd1, ry, 1'b0, 8'h02, {128'd0, ry});
        send(128'd1, ones, 1'b0, 8'h03, {128'd0, ones});
        drain();

        for (int i = 0; i < 100; i++) begin
            rx = {$urandom, $urandom, $urandom, $urandom};
            ry = {$urandom, $urandom, $urandom, $urandom};
            send(rx, ry, i[0], TAG_W'(i), model(rx, ry, i[0]));
        end
        drain();

        if (STALL) begin
            lat_chk = 1'b0;
            out_ready = 1'b0;
            for (int i = 0; i < 6; i++) begin
                send(128'(i + 1), 128'd10, 1'b0, TAG_W'(8'h40 + i),
                     256'((i + 1) * 10));
            end
            @(negedge clk);
            held = out_result;
            check("stall_head", held, 256'd10);
            check("stall_valid", 256'(out_valid), 256'(1));
            repeat (7) begin
                @(negedge clk);
                check("stall_in_ready", 256'(in_ready), 256'(0));
                check("stall_hold", out_result, held);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
            drain();
            lat_chk = 1'b1;
        end else begin
            out_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
                send(128'(i + 2), 128'd11, 1'b0, TAG_W'(8'h50 + i),
                     256'((i + 2) * 11));
                check("nostall_in_ready", 256'(in_ready), 256'(1));
            end
            drain();
            out_ready = 1'b1;
        end

        send(128'd2, 128'd9, 1'b0, 8'h60, 256'd18);
        send(128'd3, 128'd9, 1'b1, 8'h61, 256'd27);
        send(128'd4, 128'd9, 1'b0, 8'h62, 256'd36);
        idle(3);
        check("pre_rst_valid", 256'(out_valid), 256'(1));
        rst = 1'b1;
        #1;
        check("rst_async_valid", 256'(out_valid), 256'(0));
        check("rst_async_result", out_result, 256'(0));
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(8);
        check("post_rst_idle", 256'(out_valid), 256'(0));
        send(128'd5, 128'd7, 1'b0, 8'h77, 256'd35);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
